// File: rtl/arc4_key_search.sv
// arc4_key_search
// Runs one arc4 decryption core through a candidate key range to recover the
// 24-bit key of a length-prefixed ciphertext. For each candidate the block
// starts the core and snoops its plaintext writes. Any non-printable byte
// aborts the run by holding the core in reset. The search stops at the first
// key whose whole plaintext is printable, or when the key range is used up.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en             start a search (taken only while rdy=1)
//   rdy            idle and able to accept en
//   key_valid, key first printable key of the last search
//   exhausted      last search ended without finding a key
//   keys_tried     keys run to completion or aborted (saturating)
//   core_rst_n     reset to the arc4 core (system reset or abort)
//   core_en        one-cycle start pulse to the core
//   core_rdy       core idle/ready
//   core_key       key presented to the core
//   pt_wren, pt_addr, pt_wrdata   snooped plaintext write port of the core
module arc4_key_search #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter logic [23:0] KEY_STEP  = 24'h000001,
   parameter logic [23:0] KEY_MAX   = 24'hFFFFFF,
   parameter logic [7:0]  PR_LO     = 8'h20,
   parameter logic [7:0]  PR_HI     = 8'h7E
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic        key_valid,
   output logic [23:0] key,
   output logic        exhausted,
   output logic [23:0] keys_tried,
   output logic        core_rst_n,
   output logic        core_en,
   input  logic        core_rdy,
   output logic [23:0] core_key,
   input  logic        pt_wren,
   input  logic [7:0]  pt_addr,
   input  logic [7:0]  pt_wrdata
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_RUN       = 3'd3,
      S_ABORT     = 3'd4,
      S_NEXT      = 3'd5
   } state_t;

   state_t      state_r;
   logic [23:0] cur_key_r;
   logic [1:0]  abort_cnt_r;
   logic        abort_active_r;
   logic        rdy_r;
   logic        key_valid_r;
   logic [23:0] key_r;
   logic        exhausted_r;
   logic [23:0] keys_tried_r;
   logic        core_en_r;

   logic        bad_wr_s;
   logic        range_done_s;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [23:0] sat_inc24(input logic [23:0] v);
      if (v == 24'hFFFFFF) begin
         return v;
      end else begin
         return v + 24'd1;
      end
   endfunction

   // A byte outside the printable window; the length byte at address 0 is exempt.
   function automatic logic is_bad_write(input logic       wren,
                                         input logic [7:0] addr,
                                         input logic [7:0] data);
      return wren && (addr != 8'h00) && ((data < PR_LO) || (data > PR_HI));
   endfunction

   assign bad_wr_s = is_bad_write(pt_wren, pt_addr, pt_wrdata);

   // Compare in 25 bits so a step past the top of the key space cannot wrap.
   assign range_done_s = ({1'b0, cur_key_r} + {1'b0, KEY_STEP}) > {1'b0, KEY_MAX};

   // Search sequencer: state, current key, abort timer and all result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= S_IDLE;
         cur_key_r      <= 24'h000000;
         abort_cnt_r    <= 2'd0;
         abort_active_r <= 1'b0;
         rdy_r          <= 1'b1;
         key_valid_r    <= 1'b0;
         key_r          <= 24'h000000;
         exhausted_r    <= 1'b0;
         keys_tried_r   <= 24'h000000;
         core_en_r      <= 1'b0;
      end else begin
         core_en_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (en) begin
                  key_valid_r  <= 1'b0;
                  exhausted_r  <= 1'b0;
                  keys_tried_r <= 24'h000000;
                  cur_key_r    <= KEY_START;
                  rdy_r        <= 1'b0;
                  state_r      <= S_START;
               end
            end
            S_START: begin
               if (core_rdy) begin
                  core_en_r <= 1'b1;
                  state_r   <= S_WAIT_BUSY;
               end
            end
            // The core may still show ready for a few cycles after the start pulse.
            S_WAIT_BUSY: begin
               if (bad_wr_s) begin
                  abort_active_r <= 1'b1;
                  abort_cnt_r    <= 2'd0;
                  state_r        <= S_ABORT;
               end else if (!core_rdy) begin
                  state_r <= S_RUN;
               end
            end
            // A bad byte in the same cycle as completion still wins.
            S_RUN: begin
               if (bad_wr_s) begin
                  abort_active_r <= 1'b1;
                  abort_cnt_r    <= 2'd0;
                  state_r        <= S_ABORT;
               end else if (core_rdy) begin
                  key_r        <= cur_key_r;
                  key_valid_r  <= 1'b1;
                  keys_tried_r <= sat_inc24(keys_tried_r);
                  rdy_r        <= 1'b1;
                  state_r      <= S_IDLE;
               end
            end
            // Core reset is held low for two cycles.
            S_ABORT: begin
               if (abort_cnt_r == 2'd1) begin
                  abort_active_r <= 1'b0;
                  state_r        <= S_NEXT;
               end else begin
                  abort_cnt_r <= abort_cnt_r + 2'd1;
               end
            end
            S_NEXT: begin
               keys_tried_r <= sat_inc24(keys_tried_r);
               if (range_done_s) begin
                  exhausted_r <= 1'b1;
                  rdy_r       <= 1'b1;
                  state_r     <= S_IDLE;
               end else begin
                  cur_key_r <= cur_key_r + KEY_STEP;
                  state_r   <= S_START;
               end
            end
            default: begin
               abort_active_r <= 1'b0;
               rdy_r          <= 1'b1;
               state_r        <= S_IDLE;
            end
         endcase
      end
   end

   assign rdy        = rdy_r;
   assign key_valid  = key_valid_r;
   assign key        = key_r;
   assign exhausted  = exhausted_r;
   assign keys_tried = keys_tried_r;
   assign core_en    = core_en_r;
   assign core_key   = cur_key_r;
   // System reset must reach the core without waiting for a clock edge.
   assign core_rst_n = rst_n & ~abort_active_r;

endmodule

// File: tb/tb_arc4_key_search.sv
// Directed testbench for arc4_key_search. The bench plays the part of the
// arc4 core by hand. Unit 0 uses default parameters. Unit 1 searches the
// short range F0..F2.
module tb_arc4_key_search;

   logic        clk;
   logic        rst_n;
   logic [1:0]  en_v;
   logic [1:0]  core_rdy_v;
   logic [1:0]  pt_wren_v;
   logic [7:0]  pt_addr_v   [2];
   logic [7:0]  pt_wrdata_v [2];
   logic [1:0]  rdy_v;
   logic [1:0]  key_valid_v;
   logic [1:0]  exhausted_v;
   logic [1:0]  core_rst_n_v;
   logic [1:0]  core_en_v;
   logic [23:0] key_v        [2];
   logic [23:0] keys_tried_v [2];
   logic [23:0] core_key_v   [2];

   int checks = 0;
   int errors = 0;
   int en_cnt     [2];
   int rst_pulses [2];
   int rst_badlen [2];
   int rst_run    [2];
   int base_en;

   arc4_key_search dut0 (
      .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rdy(rdy_v[0]),
      .key_valid(key_valid_v[0]), .key(key_v[0]), .exhausted(exhausted_v[0]),
      .keys_tried(keys_tried_v[0]), .core_rst_n(core_rst_n_v[0]),
      .core_en(core_en_v[0]), .core_rdy(core_rdy_v[0]), .core_key(core_key_v[0]),
      .pt_wren(pt_wren_v[0]), .pt_addr(pt_addr_v[0]), .pt_wrdata(pt_wrdata_v[0])
   );

   arc4_key_search #(
      .KEY_START(24'h0000F0),
      .KEY_MAX  (24'h0000F2)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rdy(rdy_v[1]),
      .key_valid(key_valid_v[1]), .key(key_v[1]), .exhausted(exhausted_v[1]),
      .keys_tried(keys_tried_v[1]), .core_rst_n(core_rst_n_v[1]),
      .core_en(core_en_v[1]), .core_rdy(core_rdy_v[1]), .core_key(core_key_v[1]),
      .pt_wren(pt_wren_v[1]), .pt_addr(pt_addr_v[1]), .pt_wrdata(pt_wrdata_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count start pulses and measure every abort-driven core reset pulse.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (core_en_v[u]) en_cnt[u] <= en_cnt[u] + 1;
         if (rst_n && !core_rst_n_v[u]) begin
            rst_run[u] <= rst_run[u] + 1;
         end else if (rst_run[u] != 0) begin
            rst_pulses[u] <= rst_pulses[u] + 1;
            if (rst_run[u] != 2) rst_badlen[u] <= rst_badlen[u] + 1;
            rst_run[u] <= 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_search(input int u);
      en_v[u] = 1'b1;
      tick();
      en_v[u] = 1'b0;
   endtask

   // Bounded wait for the start pulse, then check the key offered to the core.
   task automatic wait_start(input int u, input logic [23:0] exp_key);
      int n;
      n = 0;
      while (!core_en_v[u] && n < 20) begin
         tick();
         n++;
      end
      check("core_en_seen", {31'd0, core_en_v[u]}, 32'd1);
      check("core_key", {8'd0, core_key_v[u]}, {8'd0, exp_key});
   endtask

   task automatic pt_write(input int u, input logic [7:0] a, input logic [7:0] d);
      pt_wren_v[u]   = 1'b1;
      pt_addr_v[u]   = a;
      pt_wrdata_v[u] = d;
      tick();
   endtask

   // Core run that emits byte 01 at address 1 and therefore gets aborted.
   task automatic bad_session(input int u, input logic [23:0] k);
      wait_start(u, k);
      core_rdy_v[u] = 1'b0;
      tick();
      pt_write(u, 8'h00, 8'h04);
      pt_write(u, 8'h01, 8'h01);
      pt_wren_v[u]  = 1'b0;
      core_rdy_v[u] = 1'b1;
      check("abort_core_rst_n", {31'd0, core_rst_n_v[u]}, 32'd0);
   endtask

   // Core run whose plaintext sits on the edges of the printable window.
   task automatic good_session(input int u, input logic [23:0] k);
      wait_start(u, k);
      core_rdy_v[u] = 1'b0;
      tick();
      pt_write(u, 8'h00, 8'h02);
      pt_write(u, 8'h01, 8'h20);
      pt_write(u, 8'h02, 8'h7E);
      pt_wren_v[u]  = 1'b0;
      core_rdy_v[u] = 1'b1;
      check("kv_before_done", {31'd0, key_valid_v[u]}, 32'd0);
      tick();
      check("kv_latency", {31'd0, key_valid_v[u]}, 32'd1);
      check("found_key", {8'd0, key_v[u]}, {8'd0, k});
   endtask

   initial begin
      rst_n      = 1'b0;
      en_v       = 2'b00;
      core_rdy_v = 2'b11;
      pt_wren_v  = 2'b00;
      for (int u = 0; u < 2; u++) begin
         pt_addr_v[u]   = 8'h00;
         pt_wrdata_v[u] = 8'h00;
      end
      repeat (2) tick();

      // Reset state
      check("rst_rdy", {31'd0, rdy_v[0]}, 32'd1);
      check("rst_key_valid", {31'd0, key_valid_v[0]}, 32'd0);
      check("rst_key", {8'd0, key_v[0]}, 32'd0);
      check("rst_exhausted", {31'd0, exhausted_v[0]}, 32'd0);
      check("rst_keys_tried", {8'd0, keys_tried_v[0]}, 32'd0);
      check("rst_core_en", {31'd0, core_en_v[0]}, 32'd0);
      check("rst_core_key", {8'd0, core_key_v[0]}, 32'd0);
      check("rst_core_rst_n", {31'd0, core_rst_n_v[0]}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Keys 0..2 rejected, key 3 accepted
      start_search(0);
      bad_session(0, 24'h000000);
      bad_session(0, 24'h000001);
      bad_session(0, 24'h000002);
      good_session(0, 24'h000003);
      check("t1_keys_tried", {8'd0, keys_tried_v[0]}, 32'd4);
      check("t1_exhausted", {31'd0, exhausted_v[0]}, 32'd0);
      check("t1_rdy", {31'd0, rdy_v[0]}, 32'd1);
      repeat (2) tick();
      check("t1_en_pulses", en_cnt[0], 32'd4);
      check("t1_rst_pulses", rst_pulses[0], 32'd3);
      check("t1_rst_len", rst_badlen[0], 32'd0);

      // Bad byte coincident with core_rdy rising
      start_search(0);
      wait_start(0, 24'h000000);
      core_rdy_v[0] = 1'b0;
      tick();
      pt_write(0, 8'h00, 8'h05);
      pt_wren_v[0]   = 1'b1;
      pt_addr_v[0]   = 8'h05;
      pt_wrdata_v[0] = 8'h7F;
      core_rdy_v[0]  = 1'b1;
      tick();
      pt_wren_v[0] = 1'b0;
      check("t3_kv", {31'd0, key_valid_v[0]}, 32'd0);
      check("t3_abort", {31'd0, core_rst_n_v[0]}, 32'd0);
      check("t3_rdy", {31'd0, rdy_v[0]}, 32'd0);
      good_session(0, 24'h000001);
      check("t3_keys_tried", {8'd0, keys_tried_v[0]}, 32'd2);

      // Zero-length message: out-of-window length byte is not checked
      start_search(0);
      wait_start(0, 24'h000000);
      core_rdy_v[0] = 1'b0;
      tick();
      pt_write(0, 8'h00, 8'h00);
      pt_wren_v[0]  = 1'b0;
      core_rdy_v[0] = 1'b1;
      tick();
      check("t4_kv", {31'd0, key_valid_v[0]}, 32'd1);
      check("t4_key", {8'd0, key_v[0]}, 32'd0);
      check("t4_keys_tried", {8'd0, keys_tried_v[0]}, 32'd1);

      // en while busy; core ready lags the start pulse by two cycles
      tick();
      base_en = en_cnt[0];
      start_search(0);
      wait_start(0, 24'h000000);
      en_v[0] = 1'b1;
      tick();
      check("t6_core_en_once_a", {31'd0, core_en_v[0]}, 32'd0);
      check("t6_busy_rdy", {31'd0, rdy_v[0]}, 32'd0);
      tick();
      check("t6_core_en_once_b", {31'd0, core_en_v[0]}, 32'd0);
      en_v[0]       = 1'b0;
      core_rdy_v[0] = 1'b0;
      tick();
      pt_write(0, 8'h00, 8'h01);
      pt_write(0, 8'h01, 8'h41);
      pt_wren_v[0]  = 1'b0;
      core_rdy_v[0] = 1'b1;
      tick();
      check("t6_kv", {31'd0, key_valid_v[0]}, 32'd1);
      check("t6_keys_tried", {8'd0, keys_tried_v[0]}, 32'd1);
      repeat (2) tick();
      check("t6_en_pulses", en_cnt[0] - base_en, 32'd1);

      // Reset during RUN
      start_search(0);
      bad_session(0, 24'h000000);
      wait_start(0, 24'h000001);
      core_rdy_v[0] = 1'b0;
      tick();
      check("t5_kt_before", {8'd0, keys_tried_v[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_core_rst_now", {31'd0, core_rst_n_v[0]}, 32'd0);
      tick();
      check("t5_core_rst_held", {31'd0, core_rst_n_v[0]}, 32'd0);
      rst_n         = 1'b1;
      core_rdy_v[0] = 1'b1;
      #1;
      check("t5_rdy", {31'd0, rdy_v[0]}, 32'd1);
      check("t5_kv", {31'd0, key_valid_v[0]}, 32'd0);
      check("t5_keys_tried", {8'd0, keys_tried_v[0]}, 32'd0);
      check("t5_core_key", {8'd0, core_key_v[0]}, 32'd0);
      check("t5_core_rst_rel", {31'd0, core_rst_n_v[0]}, 32'd1);
      tick();

      // Exhausting range F0..F2 on unit 1
      start_search(1);
      bad_session(1, 24'h0000F0);
      bad_session(1, 24'h0000F1);
      bad_session(1, 24'h0000F2);
      tick();
      check("t2_busy_abort2", {31'd0, rdy_v[1]}, 32'd0);
      repeat (2) tick();
      check("t2_exhausted", {31'd0, exhausted_v[1]}, 32'd1);
      check("t2_kv", {31'd0, key_valid_v[1]}, 32'd0);
      check("t2_keys_tried", {8'd0, keys_tried_v[1]}, 32'd3);
      check("t2_rdy", {31'd0, rdy_v[1]}, 32'd1);
      check("t2_core_key", {8'd0, core_key_v[1]}, 32'h0000F2);
      repeat (2) tick();
      check("t2_rst_pulses", rst_pulses[1], 32'd3);
      check("t2_en_pulses", en_cnt[1], 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arc4_key_search.md
Name: arc4_key_search

Overview:
- Sequences one arc4 decryption core through a candidate key range to recover the 24-bit key of a length-prefixed ciphertext.
- Starts the core for each key and snoops its plaintext writes. Any byte outside the printable window causes an early abort via the core's reset.
- Reports the first key whose full plaintext is printable, or reports that the range is exhausted.
- Sits above the arc4 core in the cracking top level. The top level owns ct/pt memories; this block only starts, aborts and watches the core.

Parameters:
KEY_START, 24'h000000, first key tried
KEY_STEP, 24'h000001, increment between keys; must be nonzero (allows interleaving several searchers)
KEY_MAX, 24'hFFFFFF, last key allowed; search ends once the next key would exceed it
PR_LO, 8'h20, lowest acceptable plaintext byte
PR_HI, 8'h7E, highest acceptable plaintext byte

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
en  in  1  start search; sampled only while rdy=1
rdy  out  1  1 when idle and able to accept en
key_valid  out  1  1 when last search found a key; held until next start
key  out  24  found key; valid when key_valid=1
exhausted  out  1  1 when last search ended with no key; held until next start
keys_tried  out  24  number of keys fully run or aborted in current/last search (saturating)
core_rst_n  out  1  reset to arc4 core; rst_n AND NOT abort_active
core_en  out  1  one-cycle start pulse to core
core_rdy  in  1  core ready/idle
core_key  out  24  key presented to core; stable from START until leaving RUN/ABORT
pt_wren  in  1  snooped core plaintext write enable
pt_addr  in  8  snooped write address; address 0 is the length byte
pt_wrdata  in  8  snooped write data

Behaviour:
- Reset values: rdy=1 (state IDLE), key_valid=0, key=0, exhausted=0, keys_tried=0, core_en=0, core_key=0, core_rst_n=0 while rst_n=0.
- Reset mid-search returns to IDLE immediately and clears all results. The core is reset through core_rst_n.
- States: IDLE, START, WAIT_BUSY, RUN, ABORT, NEXT.
- IDLE: rdy=1. On en=1, clear key_valid/exhausted/keys_tried and set cur_key=KEY_START, then go to START. en in any other state is ignored.
- START: when core_rdy=1, pulse core_en for exactly one cycle and go to WAIT_BUSY. Otherwise wait.
- WAIT_BUSY: wait for core_rdy=0, then go to RUN. This guards against rdy lagging the start pulse.
- Snooping is active in WAIT_BUSY and RUN. A write with pt_wren=1, pt_addr!=0 and pt_wrdata<PR_LO or >PR_HI is "bad" and moves to ABORT the next cycle. Writes to addr 0 are never checked.
- RUN exit:
  - core_rdy=1 with no bad write → key=cur_key, key_valid=1, keys_tried+=1, go to IDLE.
  - Bad write and core_rdy=1 in the same cycle → treated as bad (ABORT).
- ABORT: hold core_rst_n=0 for exactly 2 cycles (2-bit counter), then go to NEXT.
- NEXT: keys_tried+=1.
  - If cur_key > KEY_MAX-KEY_STEP (25-bit compare, no wrap), set exhausted=1 and go to IDLE.
  - Otherwise cur_key+=KEY_STEP and go to START.
- core_key=cur_key at all times; it changes only in NEXT or on a search start.
- Latency: end of core run (core_rdy rising) → key_valid is 1 cycle. Bad byte → next START is 4 cycles (ABORT×2, NEXT, START).
- Zero-length message (only the addr-0 write) → first key is reported found.
- keys_tried saturates at 24'hFFFFFF.
- rdy, key_valid and exhausted are never 1 with a busy state. key_valid and exhausted are mutually exclusive.

Test Plan:
1. Bench core model accepts only key 24'h000003 (printable output); others emit byte 8'h01 at addr 1. en with default params → key_valid=1, key=24'h000003, keys_tried=4, exhausted=0; three core_rst_n low pulses of 2 cycles each.
2. KEY_START=24'h0000F0, KEY_MAX=24'h0000F2, model never printable → exhausted=1, key_valid=0, keys_tried=3, rdy=1, core_key=24'h0000F2.
3. Bad byte 8'h7F at addr 5 on the same cycle core_rdy rises → aborts, key not reported, next key tried.
4. Length byte 8'h00 at addr 0 followed immediately by core_rdy → first key found; an out-of-range addr-0 value is ignored.
5. rst_n low for 1 cycle during RUN → next cycle rdy=1, key_valid=0, keys_tried=0, core_rst_n low during reset.
6. en pulsed while busy → ignored. Core holding rdy=1 for 2 cycles after core_en → stays in WAIT_BUSY, core_en pulses once only.
